hdv_stage_sequencer: RTL

- Top-level sequencer for the hdv_engine loop sub-blocks (pipelined VITIS_LOOP children).
- Runs an ap_ctrl_hs-style block-level handshake toward the host side.
- For each run, starts the enabled child stages one at a time, in ascending index order, using each child's ap_start/ap_ready/ap_done.
- Only one child is active at any time. The next child starts only after the current child's done.

---
 rtl/hdv_stage_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hdv_stage_sequencer.sv
// Top-level sequencer for the hdv_engine loop children: ap_ctrl_hs toward the host, one child active at a time.
// Optional per-stage cycle counters are enabled by defining HDV_SEQ_STAGE_CYCLES_EN.
module hdv_stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [NUM_STAGES-1:0] stage_mask,
    output logic [NUM_STAGES-1:0] child_start,
    input  logic [NUM_STAGES-1:0] child_ready,
    input  logic [NUM_STAGES-1:0] child_done,
    output logic [IDX_W-1:0]      cur_stage,
`ifdef HDV_SEQ_STAGE_CYCLES_EN
    input  logic [IDX_W-1:0]      cyc_sel,
    output logic [31:0]           cyc_count,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);

    state_t                state;
    logic [NUM_STAGES-1:0] mask_r;

    logic                  first_found;
    logic [IDX_W-1:0]      first_idx;
    logic                  next_found;
    logic [IDX_W-1:0]      next_idx;
    logic                  act_ready;
    logic                  act_done;
    logic                  running;
    logic                  advance;

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        act_ready   = 1'b0;
        act_done    = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stage_mask[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (mask_r[i] && (i > int'(cur_stage))) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
            if (IDX_W'(i) == cur_stage) begin
                act_ready = child_ready[i];
                act_done  = child_done[i];
            end
        end
    end

    assign running = (state == LAUNCH) || (state == WAIT);
    // A done seen while still launching counts as ready+done.
    assign advance = running && act_done;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= IDLE;
            mask_r      <= '0;
            ap_done     <= 1'b0;
            ap_ready    <= 1'b0;
            ap_idle     <= 1'b1;
            child_start <= '0;
            cur_stage   <= '0;
            busy        <= 1'b0;
        end else begin
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
            if (state == IDLE) begin
                if (ap_start) begin
                    mask_r  <= stage_mask;
                    ap_idle <= 1'b0;
                    if (first_found) begin
                        state       <= LAUNCH;
                        cur_stage   <= first_idx;
                        child_start <= ONE << first_idx;
                        busy        <= 1'b1;
                    end else begin
                        state    <= FINISH;
                        ap_done  <= 1'b1;
                        ap_ready <= 1'b1;
                    end
                end
            end else if (state == FINISH) begin
                state   <= IDLE;
                ap_idle <= 1'b1;
            end else if (advance) begin
                if (next_found) begin
                    state       <= LAUNCH;
                    cur_stage   <= next_idx;
                    child_start <= ONE << next_idx;
                end else begin
                    state       <= FINISH;
                    cur_stage   <= '0;
                    child_start <= '0;
                    busy        <= 1'b0;
                    ap_done     <= 1'b1;
                    ap_ready    <= 1'b1;
                end
            end else if ((state == LAUNCH) && act_ready) begin
                state       <= WAIT;
                child_start <= '0;
            end
        end
    end

`ifdef HDV_SEQ_STAGE_CYCLES_EN
    logic [31:0] cyc_cnt [NUM_STAGES];
    logic [31:0] sel_cnt;

    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (IDX_W'(i) == cyc_sel) sel_cnt = cyc_cnt[i];
        end
    end

    // Every LAUNCH/WAIT edge of a stage counts, so start-rise to done is inclusive.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_STAGES; i++) cyc_cnt[i] <= '0;
            cyc_count <= '0;
        end else begin
            cyc_count <= sel_cnt;
            for (int i = 0; i < NUM_STAGES; i++) begin
                if ((state == IDLE) && ap_start) begin
                    cyc_cnt[i] <= '0;
                end else if (running && (IDX_W'(i) == cur_stage) && (cyc_cnt[i] != 32'hFFFF_FFFF)) begin
                    cyc_cnt[i] <= cyc_cnt[i] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
